// File: rtl/stop_watch_pkg.sv
// Shared constants for the stopwatch/timer datapath: field moduli, widths and count direction.
package stop_watch_pkg;
  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;
  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;

  typedef enum logic {
    MODE_UP   = 1'b0,
    MODE_DOWN = 1'b1
  } mode_e;
endpackage

// File: rtl/updown_time_cnt.sv
// One modulo-TCNT time field counting up or down; o_carry flags the wrap in either direction.
module updown_time_cnt
  import stop_watch_pkg::*;
#(
  parameter int TCNT      = 60,
  parameter int BIT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_tick,
  input  logic                 i_dir,
  input  logic                 i_load,
  input  logic [BIT_WIDTH-1:0] i_set,
  output logic [BIT_WIDTH-1:0] o_time,
  output logic                 o_carry,
  output logic                 o_zero
);
  localparam logic [BIT_WIDTH-1:0] MAX = BIT_WIDTH'(TCNT - 1);

  logic [BIT_WIDTH-1:0] time_q, time_d;
  logic                 count_up;
  logic                 at_limit;

  assign count_up = (mode_e'(i_dir) == MODE_UP);
  assign at_limit = count_up ? (time_q == MAX) : (time_q == '0);
  assign o_carry  = i_tick && at_limit;
  assign o_zero   = (time_q == '0);
  assign o_time   = time_q;

  always_comb begin
    time_d = time_q;
    if (i_clear) begin
      time_d = '0;
    end else if (i_load) begin
      time_d = (i_set > MAX) ? MAX : i_set;
    end else if (i_tick) begin
      if (count_up) time_d = at_limit ? '0 : time_q + 1'b1;
      else          time_d = at_limit ? MAX : time_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) time_q <= '0;
    else     time_q <= time_d;
  end
endmodule

// File: rtl/stop_watch_lap_dp.sv
// Stopwatch/timer datapath: clock-enable prescaler, four cascaded time fields,
// timer expiry flag and a lap-capture FIFO.
module stop_watch_lap_dp
  import stop_watch_pkg::*;
#(
  parameter  int CLK_FREQ  = 100_000_000,
  parameter  int TICK_HZ   = 100,
  parameter  int FRAC_MOD  = 100,
  parameter  int HOUR_MOD  = 24,
  parameter  int LAP_DEPTH = 4,
  localparam int FW        = $clog2(FRAC_MOD),
  localparam int HW        = $clog2(HOUR_MOD),
  localparam int CW        = $clog2(LAP_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_run,
  input  logic             i_clear,
  input  logic             i_mode,
  input  logic             i_load,
  input  logic [FW-1:0]    i_set_frac,
  input  logic [SEC_W-1:0] i_set_sec,
  input  logic [MIN_W-1:0] i_set_min,
  input  logic [HW-1:0]    i_set_hour,
  input  logic             i_lap,
  input  logic             i_lap_rd,
  output logic [FW-1:0]    o_frac,
  output logic [SEC_W-1:0] o_sec,
  output logic [MIN_W-1:0] o_min,
  output logic [HW-1:0]    o_hour,
  output logic             o_done,
  output logic             o_ovf,
  output logic [FW-1:0]    o_lap_frac,
  output logic [SEC_W-1:0] o_lap_sec,
  output logic [MIN_W-1:0] o_lap_min,
  output logic [HW-1:0]    o_lap_hour,
  output logic             o_lap_valid,
  output logic [CW-1:0]    o_lap_count,
  output logic             o_lap_drop
);
  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int EW  = HW + MIN_W + SEC_W + FW;

  mode_e         mode;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          expired_q, expired_d;
  logic          done_q, done_d, ovf_q, ovf_d;
  logic          advance, tick_raw, time_tick;
  logic          frac_carry, sec_carry, min_carry, hour_carry;
  logic          frac_zero, sec_zero, min_zero, hour_zero, all_zero;

  assign mode      = mode_e'(i_mode);
  assign all_zero  = frac_zero && sec_zero && min_zero && hour_zero;
  assign advance   = i_run && !expired_q;
  assign tick_raw  = advance && (pcnt_q == PW'(DIV - 1));
  // Clear/load win over the tick; a countdown already at zero swallows it.
  assign time_tick = tick_raw && !i_clear && !i_load && !(mode == MODE_DOWN && all_zero);

  updown_time_cnt #(.TCNT(FRAC_MOD), .BIT_WIDTH(FW)) u_frac (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_tick(time_tick), .i_dir(i_mode),
    .i_load(i_load), .i_set(i_set_frac), .o_time(o_frac), .o_carry(frac_carry), .o_zero(frac_zero));
  updown_time_cnt #(.TCNT(SEC_MOD), .BIT_WIDTH(SEC_W)) u_sec (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_tick(frac_carry), .i_dir(i_mode),
    .i_load(i_load), .i_set(i_set_sec), .o_time(o_sec), .o_carry(sec_carry), .o_zero(sec_zero));
  updown_time_cnt #(.TCNT(MIN_MOD), .BIT_WIDTH(MIN_W)) u_min (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_tick(sec_carry), .i_dir(i_mode),
    .i_load(i_load), .i_set(i_set_min), .o_time(o_min), .o_carry(min_carry), .o_zero(min_zero));
  updown_time_cnt #(.TCNT(HOUR_MOD), .BIT_WIDTH(HW)) u_hour (
    .clk(clk), .rst(rst), .i_clear(i_clear), .i_tick(min_carry), .i_dir(i_mode),
    .i_load(i_load), .i_set(i_set_hour), .o_time(o_hour), .o_carry(hour_carry), .o_zero(hour_zero));

  always_comb begin
    pcnt_d    = pcnt_q;
    expired_d = expired_q;
    ovf_d     = time_tick && (mode == MODE_UP) && hour_carry;
    done_d    = time_tick && (mode == MODE_DOWN) && (o_frac == FW'(1))
                && sec_zero && min_zero && hour_zero;
    if (i_clear || i_load) begin
      pcnt_d    = '0;
      expired_d = 1'b0;
    end else begin
      if (advance) pcnt_d = tick_raw ? '0 : pcnt_q + 1'b1;
      if (mode == MODE_UP) expired_d = 1'b0;
      else if (done_d)     expired_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q    <= '0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      expired_q <= expired_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_done = done_q;
  assign o_ovf  = ovf_q;

  logic [EW-1:0] mem_q [LAP_DEPTH];
  logic [EW-1:0] mem_d [LAP_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          drop_q, drop_d;
  logic          full, lap_pop, lap_push;
  logic [EW-1:0] head;

  assign full     = (count_q == CW'(LAP_DEPTH));
  assign lap_pop  = i_lap_rd && (count_q != '0);
  // A pop frees the slot on the same edge, so a full FIFO still accepts the push.
  assign lap_push = i_lap && (!full || lap_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      drop_d   = 1'b0;
    end else begin
      if (lap_push) begin
        mem_d[wr_ptr_q] = {o_hour, o_min, o_sec, o_frac};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (lap_pop)          rd_ptr_d = rd_ptr_q + 1'b1;
      if (i_lap && !lap_push) drop_d = 1'b1;
      count_d = count_q + CW'(lap_push) - CW'(lap_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  assign head        = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign {o_lap_hour, o_lap_min, o_lap_sec, o_lap_frac} = head;
  assign o_lap_valid = (count_q != '0);
  assign o_lap_count = count_q;
  assign o_lap_drop  = drop_q;
endmodule

// File: tb/tb_stop_watch_lap_dp.sv
// Scoreboard bench: time kept as one integer tick count, laps as a queue of such counts.
module tb_stop_watch_lap_dp;
  localparam int CLK_FREQ  = 1000;
  localparam int TICK_HZ   = 100;
  localparam int FRAC_MOD  = 100;
  localparam int HOUR_MOD  = 24;
  localparam int LAP_DEPTH = 4;
  localparam int DIV       = CLK_FREQ / TICK_HZ;
  localparam int TOTAL     = HOUR_MOD * 3600 * FRAC_MOD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_run = 1'b0, i_clear = 1'b0, i_mode = 1'b0, i_load = 1'b0;
  logic       i_lap = 1'b0, i_lap_rd = 1'b0;
  logic [6:0] i_set_frac = '0;
  logic [5:0] i_set_sec = '0, i_set_min = '0;
  logic [4:0] i_set_hour = '0;
  logic [6:0] o_frac, o_lap_frac;
  logic [5:0] o_sec, o_min, o_lap_sec, o_lap_min;
  logic [4:0] o_hour, o_lap_hour;
  logic       o_done, o_ovf, o_lap_valid, o_lap_drop;
  logic [2:0] o_lap_count;

  stop_watch_lap_dp #(
    .CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ), .FRAC_MOD(FRAC_MOD),
    .HOUR_MOD(HOUR_MOD), .LAP_DEPTH(LAP_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .i_run(i_run), .i_clear(i_clear), .i_mode(i_mode),
    .i_load(i_load), .i_set_frac(i_set_frac), .i_set_sec(i_set_sec),
    .i_set_min(i_set_min), .i_set_hour(i_set_hour), .i_lap(i_lap), .i_lap_rd(i_lap_rd),
    .o_frac(o_frac), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
    .o_done(o_done), .o_ovf(o_ovf),
    .o_lap_frac(o_lap_frac), .o_lap_sec(o_lap_sec), .o_lap_min(o_lap_min),
    .o_lap_hour(o_lap_hour), .o_lap_valid(o_lap_valid), .o_lap_count(o_lap_count),
    .o_lap_drop(o_lap_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] tm;
    logic        done;
    logic        ovf;
    logic [23:0] lap;
    logic        lvalid;
    logic [2:0]  lcount;
    logic        ldrop;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int m_t, m_pc;
  bit m_exp, m_drop, m_done, m_ovf;
  int m_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pack_time(input int t);
    int f, s, m, h;
    f = t % FRAC_MOD;
    s = (t / FRAC_MOD) % 60;
    m = (t / (FRAC_MOD * 60)) % 60;
    h = t / (FRAC_MOD * 3600);
    return {5'(h), 6'(m), 6'(s), 7'(f)};
  endfunction

  function automatic int sat(input int v, input int modulus);
    return (v > modulus - 1) ? modulus - 1 : v;
  endfunction

  function automatic void model_reset();
    m_t = 0; m_pc = 0; m_exp = 0; m_drop = 0; m_done = 0; m_ovf = 0;
    m_q.delete();
  endfunction

  function automatic void model_step();
    bit pop, push, adv, tick;
    int t_old;
    t_old  = m_t;
    m_done = 0;
    m_ovf  = 0;
    if (i_clear) begin
      m_t = 0; m_pc = 0; m_exp = 0; m_drop = 0;
      m_q.delete();
    end else begin
      pop  = i_lap_rd && (m_q.size() > 0);
      push = i_lap && ((m_q.size() < LAP_DEPTH) || pop);
      if (i_lap && !push) m_drop = 1;
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(t_old);
      if (i_load) begin
        m_t = ((sat(int'(i_set_hour), HOUR_MOD) * 60 + sat(int'(i_set_min), 60)) * 60
               + sat(int'(i_set_sec), 60)) * FRAC_MOD + sat(int'(i_set_frac), FRAC_MOD);
        m_pc  = 0;
        m_exp = 0;
      end else begin
        adv  = i_run && !m_exp;
        tick = adv && (m_pc == DIV - 1);
        if (adv) m_pc = (m_pc + 1) % DIV;
        if (i_mode == 1'b0) m_exp = 0;
        if (tick) begin
          if (i_mode == 1'b0) begin
            m_t   = (m_t + 1) % TOTAL;
            m_ovf = (m_t == 0);
          end else if (m_t > 0) begin
            m_t = m_t - 1;
            if (m_t == 0) begin
              m_done = 1;
              m_exp  = 1;
            end
          end
        end
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.tm     = pack_time(m_t);
    e.done   = m_done;
    e.ovf    = m_ovf;
    e.lap    = (m_q.size() != 0) ? pack_time(m_q[0]) : 24'h0;
    e.lvalid = (m_q.size() != 0);
    e.lcount = 3'(m_q.size());
    e.ldrop  = m_drop;
    return e;
  endfunction

  function automatic exp_t dut_snap();
    exp_t s;
    s.tm     = {o_hour, o_min, o_sec, o_frac};
    s.done   = o_done;
    s.ovf    = o_ovf;
    s.lap    = {o_lap_hour, o_lap_min, o_lap_sec, o_lap_frac};
    s.lvalid = o_lap_valid;
    s.lcount = o_lap_count;
    s.ldrop  = o_lap_drop;
    return s;
  endfunction

  // Called at a negedge with inputs applied; returns at the next negedge.
  task automatic cyc();
    model_step();
    sb_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic run_n(input int n);
    repeat (n) cyc();
  endtask

  task automatic lap_pulse();
    i_lap = 1'b1;
    cyc();
    i_lap = 1'b0;
  endtask

  task automatic load_time(input int h, input int m, input int s, input int f);
    i_set_hour = 5'(h); i_set_min = 6'(m); i_set_sec = 6'(s); i_set_frac = 7'(f);
    i_load = 1'b1;
    cyc();
    i_load = 1'b0;
  endtask

  task automatic wait_frac(input int target);
    int n;
    n = 0;
    while (o_frac != 7'(target) && n < 300) begin
      cyc();
      n++;
    end
    check("wait_frac", 64'(o_frac), 64'(target));
  endtask

  // Monitor: compares each registered output set one step after the causing edge.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        a = dut_snap();
        check("time",  64'(a.tm), 64'(e.tm));
        check("flags", 64'({a.done, a.ovf}), 64'({e.done, e.ovf}));
        check("lap",   64'({a.lap, a.lvalid, a.lcount, a.ldrop}),
                       64'({e.lap, e.lvalid, e.lcount, e.ldrop}));
      end
    end
  end

  initial begin
    int exp_laps[4];
    exp_laps = '{3, 7, 12, 20};
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 64'(dut_snap()), 64'(0));
    rst = 1'b0;

    // Up count and resume without losing a partial tick
    i_run = 1'b1;
    run_n(1000);
    check("up_1s", 64'({o_sec, o_frac}), 64'({6'd1, 7'd0}));
    run_n(5);
    i_run = 1'b0;
    run_n(50);
    i_run = 1'b1;
    run_n(4);
    check("resume_hold", 64'(o_frac), 64'(0));
    run_n(1);
    check("resume_step", 64'(o_frac), 64'(1));

    // Full wrap
    i_run = 1'b0;
    load_time(23, 59, 59, 99);
    i_run = 1'b1;
    run_n(10);
    check("wrap_time", 64'({o_hour, o_min, o_sec, o_frac}), 64'(0));
    check("wrap_ovf", 64'(o_ovf), 64'(1));
    run_n(1);
    check("ovf_pulse_len", 64'(o_ovf), 64'(0));

    // Countdown to expiry, idle while expired, reload
    i_run  = 1'b0;
    i_mode = 1'b1;
    load_time(0, 0, 1, 0);
    i_run = 1'b1;
    run_n(1000);
    check("down_zero", 64'({o_hour, o_min, o_sec, o_frac}), 64'(0));
    check("down_done", 64'(o_done), 64'(1));
    run_n(100);
    check("expired_hold", 64'({o_sec, o_frac, o_done}), 64'(0));
    load_time(0, 0, 0, 5);
    check("reload", 64'(o_frac), 64'(5));
    run_n(50);
    check("reload_done", 64'({o_frac, o_done}), 64'({7'd0, 1'b1}));

    // Lap FIFO overflow and drain
    i_mode  = 1'b0;
    i_clear = 1'b1;
    cyc();
    i_clear = 1'b0;
    foreach (exp_laps[k]) begin
      wait_frac(exp_laps[k]);
      lap_pulse();
    end
    wait_frac(25);
    lap_pulse();
    i_run = 1'b0;
    check("lap_count_full", 64'(o_lap_count), 64'(4));
    check("lap_drop", 64'(o_lap_drop), 64'(1));
    foreach (exp_laps[k]) begin
      check("lap_head", 64'(o_lap_frac), 64'(exp_laps[k]));
      i_lap_rd = 1'b1;
      cyc();
      i_lap_rd = 1'b0;
    end
    check("lap_empty", 64'(o_lap_valid), 64'(0));

    // Push and pop together while full
    i_clear = 1'b1;
    cyc();
    i_clear = 1'b0;
    i_lap = 1'b1;
    run_n(4);
    i_lap_rd = 1'b1;
    cyc();
    i_lap = 1'b0;
    i_lap_rd = 1'b0;
    check("full_pushpop", 64'({o_lap_count, o_lap_drop}), 64'({3'd4, 1'b0}));

    // Clear beats load and lap; load saturation
    i_run = 1'b1;
    run_n(37);
    lap_pulse();
    i_clear = 1'b1; i_load = 1'b1; i_lap = 1'b1;
    i_set_min = 6'd12; i_set_sec = 6'd34; i_set_frac = 7'd56;
    cyc();
    i_clear = 1'b0; i_load = 1'b0; i_lap = 1'b0;
    check("prio_clear", 64'({o_hour, o_min, o_sec, o_frac, o_lap_count, o_lap_drop}), 64'(0));
    i_run = 1'b0;
    load_time(0, 0, 63, 0);
    check("sat_sec", 64'(o_sec), 64'(59));

    // Asynchronous reset with laps stored
    i_run = 1'b1;
    lap_pulse();
    run_n(13);
    lap_pulse();
    run_n(23);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_reset", 64'(dut_snap()), 64'(0));
    i_run = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      i_run    = ($urandom_range(0, 9) != 0);
      i_clear  = ($urandom_range(0, 299) == 0);
      i_load   = ($urandom_range(0, 99) == 0);
      i_lap    = ($urandom_range(0, 7) == 0);
      i_lap_rd = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 149) == 0) i_mode = ~i_mode;
      if (i_load) begin
        if ($urandom_range(0, 1) == 0) begin
          i_set_frac = 7'($urandom_range(0, 20));
          i_set_sec  = 6'($urandom_range(0, 1));
          i_set_min  = '0;
          i_set_hour = '0;
        end else begin
          i_set_frac = 7'($urandom);
          i_set_sec  = 6'($urandom);
          i_set_min  = 6'($urandom);
          i_set_hour = 5'($urandom);
        end
      end
      cyc();
    end
    i_run = 1'b0; i_clear = 1'b0; i_load = 1'b0; i_lap = 1'b0; i_lap_rd = 1'b0;
    run_n(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stop_watch_lap_dp.md
# stop_watch_lap_dp

Parametrised successor to the stopwatch datapath, adding a count-down timer mode, preset loading and a lap-capture FIFO. Uses a clock-enable prescaler instead of a gated clock. Sits between the button/control FSM and the FND display mux. Produces a fraction/sec/min/hour time value, an expiry pulse in timer mode, and a readable queue of captured lap times.

## Interface
Parameters:
- CLK_FREQ, 100_000_000: input clock frequency in Hz.
- TICK_HZ, 100: fraction-field tick rate. DIV = CLK_FREQ/TICK_HZ must be an integer of at least 2.
- FRAC_MOD, 100: fraction-field modulus. FW = $clog2(FRAC_MOD).
- HOUR_MOD, 24: hour-field modulus. HW = $clog2(HOUR_MOD).
- LAP_DEPTH, 4: lap FIFO entries; power of two, at least 2. CW = $clog2(LAP_DEPTH+1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_run  in  1  level; 1 = counting, 0 = hold
- i_clear  in  1  pulse; zero time, prescaler, FIFO, flags
- i_mode  in  1  0 = count up (stopwatch), 1 = count down (timer)
- i_load  in  1  pulse; load preset values
- i_set_frac / i_set_sec / i_set_min / i_set_hour  in  FW/6/6/HW  preset values
- i_lap  in  1  pulse; capture current time into FIFO
- i_lap_rd  in  1  pop FIFO head
- o_frac / o_sec / o_min / o_hour  out  FW/6/6/HW  current time
- o_done  out  1  one-cycle expiry pulse (timer mode)
- o_ovf  out  1  one-cycle pulse on up-count wrap from max to zero
- o_lap_frac / o_lap_sec / o_lap_min / o_lap_hour  out  FW/6/6/HW  FIFO head
- o_lap_valid  out  1  FIFO not empty
- o_lap_count  out  CW  entries held
- o_lap_drop  out  1  sticky; a lap was discarded because the FIFO was full

## Operation
Priority per edge: rst > i_clear > i_load > tick.

**Prescaler**
- pcnt runs 0..DIV-1 and advances only while i_run=1 and the block is not expired.
- It holds while stopped, so resume loses no partial tick.
- tick = advance && pcnt==DIV-1. On that edge pcnt wraps to 0.

**Up mode (tick)**
- frac increments; carry chain runs frac FRAC_MOD-1→0, then sec 59→0, then min 59→0, then hour HOUR_MOD-1→0.
- The full wrap from max to all-zero pulses o_ovf.

**Down mode (tick)**
- frac decrements; borrow chain runs 0→FRAC_MOD-1, then 59, then 59, then HOUR_MOD-1.
- Transition into all-zero pulses o_done and sets `expired`. While expired there are no further ticks.
- If the time is already all-zero when a tick would occur, nothing changes and there is no pulse.
- `expired` is cleared by i_clear, i_load, or i_mode=0.

**Load**
- Each field loads its preset, saturated to modulus-1 if out of range.
- pcnt is set to 0.
- The FIFO is untouched.

**Clear**
- Zeroes time, pcnt, `expired`, FIFO pointers and o_lap_drop.

**Mode change**
- Takes effect at the next tick. The time value is unchanged.

**Lap FIFO**
- i_lap pushes the time value visible on o_* in the same cycle, i.e. the pre-update value.
- If full, the push is discarded and o_lap_drop is set.
- i_lap_rd with o_lap_valid=1 pops at the edge. i_lap_rd while empty is ignored.
- Simultaneous push and pop:
  - when full: both are accepted, count is unchanged, no drop.
  - when empty: push only.
- o_lap_* equals the head entry when valid, else 0.
- i_clear and i_lap in the same cycle: clear wins and the FIFO ends empty.

## Timing
- Reset values: all outputs 0, pcnt=0, `expired`=0, FIFO empty.
- With i_run held, the time field changes exactly every DIV cycles. The first change is DIV edges after i_run rises from pcnt=0.
- Time, flags and FIFO are registered. Outputs change on the edge after the causing input or tick, with zero extra latency.
- o_done and o_ovf are high for exactly the cycle following the updating edge.
- o_lap_* are registered from FIFO storage. They are valid in the cycle after the push into an empty FIFO.
- Asynchronous rst mid-count or mid-FIFO returns everything to reset values immediately.

## Structure
- Shared package stop_watch_pkg holds:
  - field moduli SEC_MOD = 60 and MIN_MOD = 60
  - widths SEC_W = 6 and MIN_W = 6
  - MODE_UP = 0 and MODE_DOWN = 1
- Sub-module updown_time_cnt, with parameters TCNT and BIT_WIDTH, is instantiated four times. Its ports:
  - i_tick, i_dir, i_load, i_set
  - o_time
  - o_carry, asserted on wrap in either direction
  - o_zero
- The prescaler, expiry flag and lap FIFO stay in the top module.

## Test plan
Bench parameters: CLK_FREQ=1000, TICK_HZ=100 (DIV=10), FRAC_MOD=100, LAP_DEPTH=4.
- **Up count:** hold i_run for 1000 cycles → o_frac=0, o_sec=1 exactly at cycle 1000. Drop i_run at pcnt=5 for 50 cycles, re-raise → next frac step after 5 more cycles.
- **Wrap:** load 23:59:59.99 in up mode, run 10 cycles → all fields 0, o_ovf high one cycle.
- **Countdown:** load 00:00:01.00, i_mode=1, run 1000 cycles → all-zero, o_done pulse once. A further 100 cycles show no change and no pulse. i_load 00:00:00.05 → runs again.
- **Lap FIFO:** five i_lap pulses at frac 3/7/12/20/25 → o_lap_count=4, o_lap_drop=1. Reads return 3, 7, 12, 20, then o_lap_valid=0. Simultaneous lap+rd when full keeps count=4 with no new drop.
- **Priority:** i_clear, i_load and i_lap in the same cycle → time 0, FIFO empty, drop 0. i_load with i_set_sec=63 → o_sec=59.
- **Reset:** assert rst mid-run with 2 laps stored → all outputs 0 before the next clk edge.
